seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Run controller for the serial bit-pattern detectors. It holds a programmable pattern of up to MAXLEN bits and arms/disarms detection on command. It filters the serial input through a sliding window and flags each match as a Mealy output. It counts matches and stops on reaching a programmed target. It sits between the configuration/host side and the serial data stream, and replaces fixed-pattern detector instances.

## Interface
- MAXLEN, 8, maximum pattern length in bits (2..16)
- CNTW, 8, width of match counter and target
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous and active-low
- cfg_we  input  1  config write strobe
- cfg_pattern  input  MAXLEN  pattern; bit [len-1] is first-received bit
- cfg_len  input  $clog2(MAXLEN+1)  pattern length
- cfg_overlap  input  1  1 = overlapping matches allowed
- cfg_target  input  CNTW  matches to completion; 0 = unlimited
- start  input  1  arm detection
- abort  input  1  disarm immediately
- x  input  1  serial data bit
- x_valid  input  1  x is valid this cycle
- hit  output  1  combinational match flag (Mealy)
- match_cnt  output  CNTW  matches since last start
- busy  output  1  high in RUN
- done  output  1  high in DONE

## Operation
- States:
  - IDLE (reset): start → RUN.
  - RUN: abort → IDLE; a hit with match_cnt+1 == cfg_target (target≠0) → DONE.
  - DONE: start → RUN; abort → IDLE.
- Config registers load on cfg_we only in IDLE/DONE; cfg_we in RUN is ignored. Config reset values: pattern 0, len MAXLEN, overlap 1, target 0.
- cfg_len 0 is stored as 1. cfg_len > MAXLEN is stored as MAXLEN.
- On entering RUN (start): clear the window shift register, the fill counter and match_cnt.
- Each cycle with RUN & x_valid:
  - Shift x into the window (LSB is newest).
  - Increment the fill counter, saturating at MAXLEN.
- Candidate window = {window, x}. Match = low len bits equal pattern[len-1:0] and fill+1 ≥ len.
- hit = RUN & x_valid & match & ~abort.
- On hit:
  - match_cnt increments, saturating at all-ones.
  - If cfg_overlap = 0, the fill counter resets to 0, so len fresh bits are needed for the next match.
- x_valid low: no shift, no hit, state held.
- Outputs in IDLE/DONE: hit = 0. match_cnt holds its value until the next start.

## Timing
- Reset values: hit 0, match_cnt 0, busy 0, done 0, state IDLE, window 0, fill 0.
- hit is same-cycle combinational from x/x_valid. match_cnt, state, busy and done update at the following clk edge.
- start to busy: 1 cycle. A bit presented in the start cycle is not sampled; the first sampled bit is in the cycle after start.
- start and abort in the same cycle: abort wins, state becomes/stays IDLE.
- start while in RUN is ignored.
- abort in RUN: hit is suppressed in that cycle and the state goes to IDLE at the next edge. match_cnt keeps its value.
- The target-reaching hit is asserted in its cycle. done rises and busy falls at the next edge. No further hits are produced.
- Reset asserted mid-run: all state clears asynchronously and outputs take their reset values immediately.

## Structure
- Shared package: state encoding localparams (IDLE=0, RUN=1, DONE=2) and the default MAXLEN/CNTW constants, so other detector/controller blocks can use them.
- One sub-module, seq_shift_window. It contains the window shift register and fill counter, with clear, shift-enable and fill-reset inputs. The controller keeps the FSM, config registers, compare and counter.

## Test plan
- Reset, then pattern 1010, len 4, overlap 1, target 0; start, stream 1,0,1,0,1,0,1,0 with x_valid high → hit on bits 4, 6, 8; match_cnt = 3.
- Same stream with overlap 0 → hit on bits 4 and 8 only; match_cnt = 2.
- Target 2, overlap 1, same stream → hit on bits 4 and 6. done = 1 and busy = 0 one cycle after bit 6. Bits 7–8 give no hit and match_cnt stays 2.
- x_valid gaps: stream 1,0,(invalid),1,0 → single hit on the final valid 0. A 1 on x during the invalid cycle has no effect.
- Same cycle start+abort → stays IDLE. Abort in RUN during a matching bit → no hit, IDLE next cycle, match_cnt retained. cfg_we in RUN with a new pattern → the old pattern remains in effect.
- Assert rst low mid-run after 1 match → match_cnt 0, busy 0, done 0 immediately. After release the run does not resume until start.

Source files
------------

// File: rtl/seq_detect_ctrl_pkg.sv
// seq_detect_ctrl_pkg: shared state encoding and default sizing for the detector controllers
package seq_detect_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int MAXLEN_DEF = 8;
  localparam int CNTW_DEF = 8;
endpackage

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: config, control, serial stream and status signals of the run controller
interface seq_detect_ctrl_if #(
  parameter int MAXLEN = 8,
  parameter int CNTW = 8,
  parameter int LW = $clog2(MAXLEN + 1)
);
  logic cfg_we;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic cfg_overlap;
  logic [CNTW-1:0] cfg_target;
  logic start;
  logic abort;
  logic x;
  logic x_valid;
  logic hit;
  logic [CNTW-1:0] match_cnt;
  logic busy;
  logic done;
  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, x, x_valid,
    input  hit, match_cnt, busy, done
  );
  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, start, abort, x, x_valid,
    output hit, match_cnt, busy, done
  );
endinterface

// File: rtl/seq_shift_window.sv
// seq_shift_window: serial history shift register plus saturating count of bits gathered
module seq_shift_window #(
  parameter int MAXLEN = 8,
  parameter int LW = $clog2(MAXLEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift,
  input  logic fill_rst,
  input  logic x,
  output logic [MAXLEN-2:0] window,
  output logic [LW-1:0] fill
);
  localparam int WW = MAXLEN - 1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window <= '0;
      fill <= '0;
    end else if (clr) begin
      window <= '0;
      fill <= '0;
    end else begin
      if (shift) window <= WW'({window, x});
      if (fill_rst) fill <= '0;
      else if (shift && fill != LW'(MAXLEN)) fill <= fill + 1'b1;
    end
  end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with arm/abort control and match target
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input logic clk,
  input logic rst,
  seq_detect_ctrl_if.slave bus
);
  localparam int LW = $clog2(MAXLEN + 1);
  state_t state, state_n;
  logic [MAXLEN-1:0] pattern, cand, mask;
  logic [LW-1:0] len, fill;
  logic overlap, run, go, match, hit, last;
  logic [CNTW-1:0] target, cnt;
  logic [MAXLEN-2:0] window;
  assign run = state == RUN;
  assign go = ~run & bus.start & ~bus.abort;
  assign cand = {window, bus.x};
  assign mask = ~({MAXLEN{1'b1}} << len);
  assign match = ((cand ^ pattern) & mask) == '0 && ({1'b0, fill} + 1'b1) >= {1'b0, len};
  assign hit = run & bus.x_valid & match & ~bus.abort;
  assign last = target != '0 && cnt + 1'b1 == target;
  seq_shift_window #(.MAXLEN(MAXLEN)) u_win (
    .clk(clk),
    .rst(rst),
    .clr(go),
    .shift(run & bus.x_valid),
    .fill_rst(hit & ~overlap),
    .x(bus.x),
    .window(window),
    .fill(fill)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (bus.abort) state_n = IDLE;
    else if (run) state_n = (hit && last) ? DONE : RUN;
    else if (bus.start) state_n = RUN;
  end
  always_comb begin
    bus.hit = hit;
    bus.busy = run;
    bus.done = state == DONE;
    bus.match_cnt = cnt;
  end
  // config is frozen while a run is in progress; out-of-range lengths are clamped on load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= '0;
      len <= LW'(MAXLEN);
      overlap <= 1'b1;
      target <= '0;
    end else if (bus.cfg_we && !run) begin
      pattern <= bus.cfg_pattern;
      len <= (bus.cfg_len == '0) ? LW'(1) : (bus.cfg_len > LW'(MAXLEN)) ? LW'(MAXLEN) : bus.cfg_len;
      overlap <= bus.cfg_overlap;
      target <= bus.cfg_target;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (go) cnt <= '0;
    else if (hit && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed test-plan sequences plus random traffic against a bit-history model
module tb_seq_detect_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  seq_detect_ctrl_if #(.MAXLEN(8), .CNTW(8)) bus ();
  seq_detect_ctrl #(.MAXLEN(8), .CNTW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    bit hit;
    bit busy;
    bit done;
    int cnt;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int m_state;
  bit [7:0] m_pat;
  int m_len;
  bit m_ov;
  int m_tgt;
  int m_cnt;
  bit hist[$];
  function automatic void model_reset();
    m_state = 0;
    m_pat = 0;
    m_len = 8;
    m_ov = 1;
    m_tgt = 0;
    m_cnt = 0;
    hist.delete();
  endfunction
  function automatic bit model_hit(bit xb, bit xv, bit ab);
    if (m_state != 1 || !xv || ab) return 0;
    if (hist.size() + 1 < m_len) return 0;
    for (int i = 0; i < m_len; i++) begin
      bit b;
      b = (i == 0) ? xb : hist[hist.size() - i];
      if (b != m_pat[i]) return 0;
    end
    return 1;
  endfunction
  function automatic void model_update(bit we, bit [7:0] pat, int len, bit ov, int tgt,
                                       bit st, bit ab, bit xb, bit xv, bit h);
    int old, pre;
    old = m_state;
    pre = m_cnt;
    if (old == 1) begin
      if (xv) hist.push_back(xb);
      if (h) begin
        m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        if (!m_ov) hist.delete();
      end
      while (hist.size() > 16) void'(hist.pop_front());
    end
    if (ab) m_state = 0;
    else if (old == 1) m_state = (h && m_tgt != 0 && ((pre + 1) % 256) == m_tgt) ? 2 : 1;
    else if (st) begin
      m_state = 1;
      m_cnt = 0;
      hist.delete();
    end
    if (old != 1 && we) begin
      m_pat = pat;
      m_len = (len == 0) ? 1 : (len > 8) ? 8 : len;
      m_ov = ov;
      m_tgt = tgt;
    end
  endfunction
  task automatic step(input bit we, input bit [7:0] pat, input int len, input bit ov,
                      input int tgt, input bit st, input bit ab, input bit xb, input bit xv);
    exp_t e;
    bus.cfg_we = we;
    bus.cfg_pattern = pat;
    bus.cfg_len = 4'(len);
    bus.cfg_overlap = ov;
    bus.cfg_target = 8'(tgt);
    bus.start = st;
    bus.abort = ab;
    bus.x = xb;
    bus.x_valid = xv;
    e.hit = model_hit(xb, xv, ab);
    e.busy = m_state == 1;
    e.done = m_state == 2;
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    model_update(we, pat, len, ov, tgt, st, ab, xb, xv, e.hit);
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cfg(input bit [7:0] pat, input int len, input bit ov, input int tgt);
    step(1, pat, len, ov, tgt, 0, 0, 0, 0);
  endtask
  task automatic go();
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask
  task automatic bit_in(input bit xb, input bit xv);
    step(0, 0, 0, 0, 0, 0, 0, xb, xv);
  endtask
  task automatic stream1010();
    for (int i = 0; i < 8; i++) bit_in(i % 2 == 0, 1);
  endtask
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (bus.hit !== e.hit || bus.busy !== e.busy || bus.done !== e.done || bus.match_cnt !== 8'(e.cnt)) begin
        bad++;
        $display("FAIL scoreboard t=%0t hit/busy/done/cnt got=%b/%b/%b/%0d want=%b/%b/%b/%0d",
                 $time, bus.hit, bus.busy, bus.done, bus.match_cnt, e.hit, e.busy, e.done, e.cnt);
      end
    end
  end
  initial begin
    model_reset();
    bus.cfg_we = 0;
    bus.cfg_pattern = 0;
    bus.cfg_len = 0;
    bus.cfg_overlap = 0;
    bus.cfg_target = 0;
    bus.start = 0;
    bus.abort = 0;
    bus.x = 0;
    bus.x_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cnt", int'(bus.match_cnt), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_hit", int'(bus.hit), 0);
    rst = 1;
    cfg(8'b1010, 4, 1, 0);
    go();
    stream1010();
    chk("ovl_cnt", int'(bus.match_cnt), 3);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cfg(8'b1010, 4, 0, 0);
    go();
    stream1010();
    chk("novl_cnt", int'(bus.match_cnt), 2);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cfg(8'b1010, 4, 1, 2);
    go();
    for (int i = 0; i < 6; i++) bit_in(i % 2 == 0, 1);
    chk("tgt_done", int'(bus.done), 1);
    chk("tgt_busy", int'(bus.busy), 0);
    bit_in(1, 1);
    bit_in(0, 1);
    chk("tgt_cnt", int'(bus.match_cnt), 2);
    cfg(8'b1010, 4, 1, 0);
    go();
    bit_in(1, 1);
    bit_in(0, 1);
    bit_in(1, 0);
    bit_in(1, 1);
    bit_in(0, 1);
    chk("gap_cnt", int'(bus.match_cnt), 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("start_abort_busy", int'(bus.busy), 0);
    go();
    for (int i = 0; i < 5; i++) bit_in(i % 2 == 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_cnt", int'(bus.match_cnt), 1);
    go();
    step(1, 8'b0110, 4, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) bit_in(i % 2 == 0, 1);
    chk("cfg_in_run_cnt", int'(bus.match_cnt), 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    go();
    for (int i = 0; i < 5; i++) bit_in(i % 2 == 0, 1);
    begin
      exp_t e;
      rst = 0;
      model_reset();
      bus.start = 0;
      bus.abort = 0;
      bus.cfg_we = 0;
      bus.x = 0;
      bus.x_valid = 1;
      e.hit = 0;
      e.busy = 0;
      e.done = 0;
      e.cnt = 0;
      q.push_back(e);
      #1;
      chk("async_rst_cnt", int'(bus.match_cnt), 0);
      chk("async_rst_busy", int'(bus.busy), 0);
      @(posedge clk);
      #1;
      rst = 1;
    end
    for (int i = 0; i < 6; i++) bit_in(i % 2 == 0, 1);
    chk("no_resume_busy", int'(bus.busy), 0);
    for (int n = 0; n < 3000; n++) begin
      bit we, ov, st, ab, xb, xv;
      int len;
      we = ($urandom % 12) == 0;
      ov = $urandom % 2;
      st = ($urandom % 8) == 0;
      ab = ($urandom % 30) == 0;
      xb = $urandom % 2;
      xv = ($urandom % 5) != 0;
      len = (($urandom % 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
      step(we, 8'($urandom), len, ov, int'($urandom_range(0, 5)), st, ab, xb, xv);
    end
    idle();
    @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
